// File: rtl/branch_predict_bht.sv
// Decode-stage branch direction predictor: static, bimodal or gshare
// 2-bit counter table, trained non-speculatively from Execute.
module branch_predict_bht #(
    parameter int PHT_DEPTH = 256,
    parameter int GHR_WIDTH = 8,
    parameter int MODE      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcD,
    input  logic [31:0] instrD,
    input  logic [31:0] immD,
    output logic        branchD,
    output logic        pred_takeD,
    input  logic        stallE,
    input  logic        branchE,
    input  logic [31:0] pcE,
    input  logic        actual_takeE,
    input  logic        pred_takeE,
    output logic        mispredictE,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IW = $clog2(PHT_DEPTH);

    logic [1:0]           pht_q [PHT_DEPTH];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;

    logic [IW-1:0] hist_ext;
    logic [IW-1:0] idx_dec;
    logic [IW-1:0] idx_exe;
    logic [1:0]    ctr_dec;
    logic [1:0]    ctr_exe;
    logic [1:0]    ctr_new;
    logic          is_regimm;
    logic          is_cmp_br;
    logic          dyn_pred;
    logic          upd;
    logic          unused;

    assign unused = ^{pcD[31:IW+2], pcD[1:0], pcE[31:IW+2], pcE[1:0],
                      instrD[25:20], instrD[16:0], immD[30:0]};

    // Decode: REGIMM branches and the beq/bne/blez/bgtz opcode group
    assign is_regimm = (instrD[31:26] == 6'b000001) && (instrD[19:17] == 3'b000);
    assign is_cmp_br = (instrD[31:28] == 4'b0001);
    assign branchD   = is_regimm | is_cmp_br;

    // History only folds into the index in gshare mode
    assign hist_ext = (MODE == 2) ? IW'(ghr_q) : '0;
    assign idx_dec  = pcD[IW+1:2] ^ hist_ext;
    assign idx_exe  = pcE[IW+1:2] ^ hist_ext;

    assign ctr_dec    = pht_q[idx_dec];
    assign dyn_pred   = ctr_dec[1];
    assign pred_takeD = branchD & ((MODE == 0) ? immD[31] : dyn_pred);

    assign mispredictE = branchE & (pred_takeE ^ actual_takeE);
    assign upd         = branchE & ~stallE;

    assign ctr_exe = pht_q[idx_exe];

    always_comb begin
        ctr_new = ctr_exe;
        if (actual_takeE) begin
            if (ctr_exe != 2'b11) ctr_new = ctr_exe + 2'b01;
        end else begin
            if (ctr_exe != 2'b00) ctr_new = ctr_exe - 2'b01;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (upd && (MODE == 2)) ghr_d = (ghr_q << 1) | GHR_WIDTH'(actual_takeE);
    end

    // Statistics counters saturate instead of wrapping
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd && (branch_cnt_q != 32'hFFFF_FFFF))
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (upd && mispredictE && (miss_cnt_q != 32'hFFFF_FFFF))
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
            ghr_q        <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (upd && (MODE != 0)) pht_q[idx_exe] <= ctr_new;
            ghr_q        <= ghr_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_bht.sv
// Directed bench: static, bimodal and gshare instances driven
// from one shared stimulus set.
module tb_branch_predict_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcD, instrD, immD, pcE;
    logic        stallE, branchE, actual_takeE, pred_takeE;

    logic        br0, pt0, mp0, br1, pt1, mp1, br2, pt2, mp2;
    logic [31:0] bc0, mc0, bc1, mc1, bc2, mc2;

    int errs   = 0;
    int checks = 0;

    localparam logic [31:0] BEQ  = 32'h1000_0004;
    localparam logic [31:0] ADDU = 32'h0000_0821;
    localparam logic [31:0] P    = 32'h0040_0100;

    always #5 clk = ~clk;

    branch_predict_bht #(.PHT_DEPTH(256), .GHR_WIDTH(8), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .pcD(pcD), .instrD(instrD), .immD(immD),
        .branchD(br0), .pred_takeD(pt0), .stallE(stallE), .branchE(branchE),
        .pcE(pcE), .actual_takeE(actual_takeE), .pred_takeE(pred_takeE),
        .mispredictE(mp0), .branch_cnt(bc0), .miss_cnt(mc0));

    branch_predict_bht #(.PHT_DEPTH(256), .GHR_WIDTH(8), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .pcD(pcD), .instrD(instrD), .immD(immD),
        .branchD(br1), .pred_takeD(pt1), .stallE(stallE), .branchE(branchE),
        .pcE(pcE), .actual_takeE(actual_takeE), .pred_takeE(pred_takeE),
        .mispredictE(mp1), .branch_cnt(bc1), .miss_cnt(mc1));

    branch_predict_bht #(.PHT_DEPTH(256), .GHR_WIDTH(4), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .pcD(pcD), .instrD(instrD), .immD(immD),
        .branchD(br2), .pred_takeD(pt2), .stallE(stallE), .branchE(branchE),
        .pcE(pcE), .actual_takeE(actual_takeE), .pred_takeE(pred_takeE),
        .mispredictE(mp2), .branch_cnt(bc2), .miss_cnt(mc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic act, input logic prd);
        branchE      = 1'b1;
        pcE          = pc;
        actual_takeE = act;
        pred_takeE   = prd;
        tick();
        branchE = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pcD = P; instrD = BEQ; immD = '0; pcE = P;
        stallE = 1'b0; branchE = 1'b0; actual_takeE = 1'b0; pred_takeE = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_bcnt", bc1, 32'd0);
        chk("rst_mcnt", mc1, 32'd0);
        chk("rst_ghr", 32'(u_m2.ghr_q), 32'd0);
        chk("rst_pred_m1", 32'(pt1), 32'd0);
        chk("rst_pred_m2", 32'(pt2), 32'd0);

        // static mode and decode
        immD = 32'hFFFF_FFF0; #1;
        chk("m0_back", 32'(pt0), 32'd1);
        chk("m0_br", 32'(br0), 32'd1);
        immD = 32'h0000_0010; #1;
        chk("m0_fwd", 32'(pt0), 32'd0);
        instrD = ADDU; immD = 32'hFFFF_FFF0; #1;
        chk("addu_br", 32'({br0, br1, br2}), 32'd0);
        chk("addu_pt", 32'({pt0, pt1, pt2}), 32'd0);
        instrD = 32'h0400_FFF0; #1;
        chk("regimm_br", 32'(br1), 32'd1);
        instrD = 32'h0402_0000; #1;
        chk("regimm_bad", 32'(br1), 32'd0);
        instrD = BEQ; immD = '0; #1;

        // bimodal training at P
        upd(P, 1'b1, 1'b0);
        upd(P, 1'b1, 1'b1);
        chk("bim_tt", 32'(pt1), 32'd1);
        upd(P, 1'b1, 1'b1);
        upd(P, 1'b0, 1'b1);
        chk("bim_sat_hi", 32'(pt1), 32'd1);
        upd(P, 1'b0, 1'b1);
        chk("bim_01", 32'(pt1), 32'd0);
        upd(P, 1'b0, 1'b0);
        upd(P, 1'b0, 1'b0);
        chk("bim_00", 32'(pt1), 32'd0);
        upd(P, 1'b1, 1'b0);
        chk("bim_sat_lo", 32'(pt1), 32'd0);
        upd(P, 1'b1, 1'b0);
        chk("bim_10", 32'(pt1), 32'd1);

        // same-index read during write sees old counter
        branchE = 1'b1; pcE = P; actual_takeE = 1'b0; pred_takeE = 1'b1;
        #2;
        chk("rw_old", 32'(pt1), 32'd1);
        chk("mp_comb", 32'(mp1), 32'd1);
        tick();
        branchE = 1'b0; #1;
        chk("rw_new", 32'(pt1), 32'd0);
        chk("mp_idle", 32'(mp1), 32'd0);

        // stall blocks all updates
        do_reset();
        stallE = 1'b1; branchE = 1'b1; actual_takeE = 1'b1; pred_takeE = 1'b0; pcE = P;
        repeat (3) tick();
        stallE = 1'b0; branchE = 1'b0; #1;
        chk("stall_pred", 32'(pt1), 32'd0);
        chk("stall_bcnt", bc1, 32'd0);
        chk("stall_mcnt", mc1, 32'd0);
        chk("stall_ghr", 32'(u_m2.ghr_q), 32'd0);

        // branchE low ignores other Execute inputs
        actual_takeE = 1'b1; pred_takeE = 1'b0;
        tick();
        chk("idle_bcnt", bc1, 32'd0);

        // gshare history
        upd(32'h0040_0000, 1'b1, 1'b0);
        upd(32'h0040_0000, 1'b0, 1'b0);
        upd(32'h0040_0000, 1'b1, 1'b0);
        upd(32'h0040_0000, 1'b1, 1'b0);
        chk("ghr_1011", 32'(u_m2.ghr_q), 32'h0000_000B);
        pcD = 32'h0040_0000; #1;
        chk("gs_idx", 32'(u_m2.idx_dec), 32'h0000_000B);
        chk("gs_pred_b", 32'(pt2), 32'd0);
        pcD = 32'h0040_0038; #1;
        chk("gs_pred_5", 32'(pt2), 32'd1);
        pcD = 32'h0040_0028; #1;
        chk("gs_pred_1", 32'(pt2), 32'd0);
        pcD = P;

        // counts and reset during an update
        do_reset();
        for (int i = 0; i < 10; i++) upd(P, 1'b1, (i % 3 == 0 && i < 9) ? 1'b0 : 1'b1);
        chk("cnt_br", bc1, 32'd10);
        chk("cnt_miss", mc1, 32'd3);
        chk("cnt_br_m0", bc0, 32'd10);
        chk("cnt_trained", 32'(pt1), 32'd1);
        rst = 1'b1;
        upd(P, 1'b1, 1'b0);
        rst = 1'b0; #1;
        chk("rstu_bcnt", bc1, 32'd0);
        chk("rstu_mcnt", mc1, 32'd0);
        chk("rstu_ghr", 32'(u_m2.ghr_q), 32'd0);
        chk("rstu_pred", 32'(pt1), 32'd0);

        // saturation of the branch counter
        force u_m1.branch_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_m1.branch_cnt_q;
        upd(P, 1'b1, 1'b1);
        upd(P, 1'b1, 1'b1);
        chk("cnt_sat", bc1, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_bht.md
BRANCH_PREDICT_BHT -- requirements
Module: branch_predict_bht

Interface
REQ-001 Parameter PHT_DEPTH, default 256: number of 2-bit counters; SHALL be a power of two, 16 to 4096.
REQ-002 Parameter GHR_WIDTH, default 8: global history bits; SHALL satisfy 1 <= GHR_WIDTH <= log2(PHT_DEPTH).
REQ-003 Parameter MODE, default 2: 0 = static backward-taken, 1 = bimodal, 2 = gshare.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pcD  in  32  PC of the instruction in Decode.
REQ-007 instrD  in  32  instruction word in Decode.
REQ-008 immD  in  32  sign-extended branch offset in Decode.
REQ-009 branchD  out  1  Decode instruction is a conditional branch.
REQ-010 pred_takeD  out  1  predicted direction for the Decode branch.
REQ-011 stallE  in  1  Execute stalled; no update or count that cycle.
REQ-012 branchE  in  1  Execute holds a resolved conditional branch.
REQ-013 pcE  in  32  PC of the Execute branch.
REQ-014 actual_takeE  in  1  resolved direction.
REQ-015 pred_takeE  in  1  prediction carried down the pipe with the branch.
REQ-016 mispredictE  out  1  branchE & (pred_takeE ^ actual_takeE), combinational.
REQ-017 branch_cnt  out  32  resolved-branch count.
REQ-018 miss_cnt  out  32  misprediction count.

Function
REQ-019 branchD SHALL be 1 iff (opcode == 6'b000001 and instrD[19:17] == 3'b000) or instrD[31:28] == 4'b0001; combinational.
REQ-020 Index width IW = log2(PHT_DEPTH); pc_idx(pc) = pc[IW+1:2].
REQ-021 MODE 1 index = pc_idx; MODE 2 index = pc_idx XOR {zeros, GHR}, GHR zero-extended into the low bits.
REQ-022 MODE 0: pred_takeD = branchD & immD[31]; table, GHR and counters other than branch_cnt/miss_cnt SHALL not be read.
REQ-023 MODE 1/2: pred_takeD = branchD & counter[indexD][1]; combinational read, zero latency.
REQ-024 Counter update (MODE 1/2) when branchE & ~stallE & ~rst: index from pcE with current GHR; taken -> saturating +1 (max 2'b11), not taken -> saturating -1 (min 2'b00).
REQ-025 GHR (MODE 2) SHALL shift left on the same update condition, LSB = actual_takeE; non-speculative, oldest bit dropped.
REQ-026 Decode read and Execute write on the same index in one cycle: read SHALL return the pre-update value (no bypass).
REQ-027 Decode gshare index SHALL use the GHR value before that cycle's shift.
REQ-028 branch_cnt +1 when branchE & ~stallE; miss_cnt +1 when mispredictE & ~stallE; both saturate at 32'hFFFF_FFFF, no wrap.
REQ-029 branchE low: no state change regardless of other Execute inputs.
REQ-030 pred_takeD and branchD SHALL be 0 for non-branch instructions in all modes.

Reset
REQ-031 On rst high at a clock edge: all counters <- 2'b01 (weakly not-taken), GHR <- 0, branch_cnt <- 0, miss_cnt <- 0, in that single edge.
REQ-032 rst SHALL override any simultaneous update; reset during an in-flight branch discards that update.
REQ-033 After reset, MODE 1/2 SHALL predict not-taken for every branch until trained; outputs are combinational, so no reset value beyond that implied by state.

Verification
REQ-034 MODE 0, beq with immD = 32'hFFFF_FFF0 -> pred_takeD = 1; immD = 32'h0000_0010 -> 0; addu instr -> branchD = 0, pred_takeD = 0.
REQ-035 MODE 1, after reset, pcD = pcE = 0x0040_0100, two taken updates -> counter 2'b11, pred_takeD = 1; three not-taken -> 2'b00, pred_takeD = 0; a fourth not-taken stays 2'b00.
REQ-036 MODE 2, GHR_WIDTH = 4, taken sequence 1,0,1,1 -> GHR = 4'b1011; next lookup for pc 0x0040_0000 uses index 0x0B.
REQ-037 stallE = 1 with branchE = 1, actual_takeE = 1 for 3 cycles -> no counter, GHR or count change; same-index read/write cycle returns old counter.
REQ-038 Run 10 branches with 3 mispredicts -> branch_cnt = 10, miss_cnt = 3; assert rst concurrently with an update -> all state at reset values next cycle.
REQ-039 Preload branch_cnt at 32'hFFFF_FFFE (force), two more branches -> 32'hFFFF_FFFF held.
